ldl_acc_sched: RTL and testbench

- Batch scheduler that shares one external accumulator register (y <= y + x, with clr/en) among NREQ requesters.
- On start, it clears the accumulator and then round-robin grants len samples from requesting sources into it.
- It then presents the sum on a valid/ready result port.
- Sits between several sample producers and a single shared accumulate register.

---
 rtl/ldl_acc_sched.sv | 107 ++++++++++
 tb/tb_ldl_acc_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_acc_sched.sv
// Batch scheduler sharing one external y <= y + x accumulator among NREQ requesters:
// clears it, grants len samples round-robin, then offers the sum on a valid/ready port.
module ldl_acc_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  abort,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] x,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic [WIDTH-1:0]      acc_x,
  input  logic [WIDTH-1:0]      acc_y,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CLR, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_found && req[(int'(ptr_q) + k) % NREQ]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ptr_d     = ptr_q;
    gnt       = '0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    acc_x     = '0;
    res_valid = 1'b0;
    res_data  = '0;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = len;
          state_d = CLR;
        end
      end
      CLR: begin
        acc_clr = 1'b1;
        if (abort)                state_d = IDLE;
        else if (rem_q == '0)     state_d = HOLD;
        else                      state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sel_found && rem_q != '0) begin
          gnt[sel_idx] = 1'b1;
          acc_en       = 1'b1;
          acc_x        = x[int'(sel_idx)*WIDTH +: WIDTH];
          rem_d        = rem_q - 1'b1;
          ptr_d        = (sel_idx == PTR_W'(NREQ-1)) ? '0 : sel_idx + 1'b1;
          if (rem_q == LEN_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        // HOLD follows the last acc_en by one cycle, so acc_y already holds the full sum.
        res_valid = 1'b1;
        res_data  = acc_y;
        if (abort || res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_ldl_acc_sched.sv
// Randomized and directed bench for ldl_acc_sched against a transaction-level model
// (expected grant order and batch sum) plus a behavioural external accumulator.
module tb_ldl_acc_sched;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int LW = 4;

  logic           clk = 1'b0;
  logic           rst_n, start, abort, res_ready;
  logic [LW-1:0]  len;
  logic [N-1:0]   req;
  logic [N*W-1:0] x;
  logic [N-1:0]   gnt;
  logic           busy, acc_clr, acc_en, res_valid;
  logic [W-1:0]   acc_x, res_data;
  logic [W-1:0]   acc_q = '0;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;
  int m_sum    = 0;
  logic [W-1:0] last_res;

  ldl_acc_sched #(.WIDTH(W), .NREQ(N), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .req(req), .x(x), .gnt(gnt), .busy(busy), .acc_clr(acc_clr),
    .acc_en(acc_en), .acc_x(acc_x), .acc_y(acc_q), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // External shared accumulator; deliberately untouched by rst_n.
  always @(posedge clk) begin
    if (acc_clr)     acc_q <= '0;
    else if (acc_en) acc_q <= acc_q + acc_x;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic batch(input int blen, input logic [N-1:0] freq, input bit rx,
                       input int stall_after, input int stall_cycles,
                       input int hold_wait, input bit start_abort);
    int granted    = 0;
    int stall_left = stall_cycles;
    int cyc        = 0;
    int g;
    int xv;
    logic [N-1:0] r;
    start = 1'b1; len = blen[LW-1:0]; abort = start_abort; res_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    tick();
    start = 1'b0; abort = 1'b0; len = LW'($urandom);
    #1;
    chk("clr_pulse", acc_clr, 1);
    chk("clr_busy", busy, 1);
    chk("clr_en", acc_en, 0);
    chk("clr_valid", res_valid, 0);
    tick();
    m_sum = 0;
    while (granted < blen) begin
      if (rx) x = $urandom;
      if (granted == stall_after && stall_left > 0) begin
        r = '0;
        stall_left--;
      end else if (freq != '0) r = freq;
      else r = N'($urandom);
      req = r; len = LW'($urandom);
      #1;
      g = rr_pick(r, m_ptr);
      if (g < 0) begin
        chk("stall_gnt", gnt, 0);
        chk("stall_en", acc_en, 0);
        chk("stall_x", acc_x, 0);
      end else begin
        xv = int'(x[g*W +: W]);
        chk("run_gnt", gnt, 32'(1) << g);
        chk("run_en", acc_en, 1);
        chk("run_x", acc_x, xv);
        m_sum = m_sum + xv;
        m_ptr = (g + 1) % N;
        granted++;
      end
      chk("run_clr", acc_clr, 0);
      chk("run_valid", res_valid, 0);
      tick();
      cyc++;
      if (cyc > 300) begin
        chk("run_timeout", granted, blen);
        break;
      end
    end
    for (int i = 0; i <= hold_wait; i++) begin
      req = N'($urandom); x = $urandom; start = 1'($urandom_range(0, 1));
      res_ready = (i == hold_wait);
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, m_sum % 256);
      chk("hold_gnt", gnt, 0);
      chk("hold_en", acc_en, 0);
      chk("hold_clr", acc_clr, 0);
      chk("hold_busy", busy, 1);
      last_res = res_data;
      tick();
    end
    start = 1'b0; res_ready = 1'b0; req = '0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_valid", res_valid, 0);
  endtask

  initial begin
    int g;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    len = '0; req = '0; x = '0;
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr", acc_clr, 0);
    chk("rst_en", acc_en, 0);
    chk("rst_x", acc_x, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    m_ptr = 0;

    // Basic batch, then round-robin continuation.
    x = 32'h04030201;
    batch(3, 4'b1111, 1'b0, 0, 0, 3, 1'b0);
    chk("t1_sum", last_res, 6);
    x = 32'h04030201;
    batch(2, 4'b1111, 1'b0, 0, 0, 0, 1'b0);
    chk("t2_sum", last_res, 5);
    x = 32'h04030201;
    batch(3, 4'b0101, 1'b0, 0, 0, 1, 1'b0);

    // Wrap-around: 200 + 100 mod 256.
    x = {8'd0, 8'd0, 8'd100, 8'd200};
    batch(2, 4'b0011, 1'b0, 0, 0, 0, 1'b0);
    chk("t3_wrap", last_res, 44);

    // Zero length and stall.
    batch(0, 4'b1111, 1'b1, 0, 0, 1, 1'b0);
    chk("t4_zero", last_res, 0);
    batch(4, 4'b1111, 1'b1, 2, 5, 0, 1'b0);

    // Abort after one grant.
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    tick();
    req = 4'b1111; x = $urandom;
    #1;
    g = rr_pick(req, m_ptr);
    chk("ab_gnt1", gnt, 32'(1) << g);
    m_ptr = (g + 1) % N;
    tick();
    abort = 1'b1;
    #1;
    chk("ab_gnt0", gnt, 0);
    chk("ab_en0", acc_en, 0);
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ab_busy", busy, 0);
      chk("ab_valid", res_valid, 0);
      tick();
    end

    // Reset in the middle of HOLD.
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    tick();
    req = 4'b1111;
    tick();
    req = '0;
    #1;
    chk("rh_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rh_rst_valid", res_valid, 0);
    chk("rh_rst_busy", busy, 0);
    chk("rh_rst_data", res_data, 0);
    m_ptr = 0;
    tick();
    rst_n = 1'b1;
    batch(1, 4'b1111, 1'b1, 0, 0, 0, 1'b1);

    // Randomized batches.
    for (int b = 0; b < 12; b++) begin
      batch($urandom_range(0, 15), 4'b0000, 1'b1, $urandom_range(0, 15),
            $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
